// File: rtl/upsample_pkg.sv
// Shared types and helpers for the 2x nearest-neighbour upsampler.
// Optional o_last output is enabled with UPSAMPLE_LAST_EN.
package upsample_pkg;

    typedef enum logic {S_FIRST, S_REPLAY} ups_state_t;

    // Counter width for n states, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/upsample_if.sv
// Input and output pixel streams of the upsampler (rdy = valid, ack = accept).
// o_last is present only when UPSAMPLE_LAST_EN is defined.
interface upsample_if #(
    parameter int DW = 8
) ();

    logic          i_rdy;
    logic          i_ack;
    logic [DW-1:0] i_data;
    logic          o_rdy;
    logic          o_ack;
    logic [DW-1:0] o_data;
`ifdef UPSAMPLE_LAST_EN
    logic          o_last;
`endif

    // master: the surrounding environment (source upstream, sink downstream)
    modport master (
        output i_rdy, i_data, o_ack,
        input  i_ack, o_rdy, o_data
`ifdef UPSAMPLE_LAST_EN
        , input o_last
`endif
    );

    // slave: the upsampler itself
    modport slave (
        input  i_rdy, i_data, o_ack,
        output i_ack, o_rdy, o_data
`ifdef UPSAMPLE_LAST_EN
        , output o_last
`endif
    );

endinterface

// File: rtl/upsample_linebuf.sv
// One-row line buffer: flop array, one synchronous write port, one asynchronous read port.
module upsample_linebuf
    import upsample_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 8,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/upsample.sv
// 2x nearest-neighbour upsampler: each pixel sent twice, each row replayed from a line buffer.
// Define UPSAMPLE_LAST_EN to add the registered end-of-frame flag o_last.
module upsample
    import upsample_pkg::*;
#(
    parameter int DW   = 8,
    parameter int IN_W = 8,
    parameter int IN_H = 8
) (
    input logic       clk,
    input logic       rst,
    upsample_if.slave bus
);

    localparam int CW = cnt_w(IN_W);
    localparam int RW = cnt_w(IN_H);
    localparam logic [CW-1:0] LAST_COL = CW'(IN_W - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IN_H - 1);

    ups_state_t    state, state_n;
    logic [DW-1:0] hold_p1, hold_n;
    logic          vld_p1, vld_n;
    logic [CW-1:0] col, col_n, col_inc;
    logic [RW-1:0] row, row_n;
    logic          dup, dup_n;
    logic          i_ack_c, xfer_in, xfer_out;
    logic [CW-1:0] waddr, raddr;
    logic [DW-1:0] rdata;

    // The overlap path is closed on the last column because that slot hands over to the replay.
    assign i_ack_c  = !rst && (state == S_FIRST) &&
                      (!vld_p1 || (bus.o_ack && dup && (col != LAST_COL)));
    assign xfer_in  = bus.i_rdy && i_ack_c;
    assign xfer_out = vld_p1 && bus.o_ack;
    assign col_inc  = (col == LAST_COL) ? '0 : col + 1'b1;

    // An input arriving while a pixel is still held belongs to the next column.
    assign waddr = vld_p1 ? col_inc : col;
    assign raddr = (state == S_FIRST) ? '0 : col_inc;

    upsample_linebuf #(.DW(DW), .DEPTH(IN_W), .AW(CW)) u_linebuf (
        .clk   (clk),
        .we    (xfer_in),
        .waddr (waddr),
        .wdata (bus.i_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_comb begin
        state_n = state;
        hold_n  = hold_p1;
        vld_n   = vld_p1;
        col_n   = col;
        row_n   = row;
        dup_n   = dup;
        if (xfer_out) begin
            dup_n = ~dup;
        end
        case (state)
            S_FIRST: begin
                if (xfer_out && dup) begin
                    if (col == LAST_COL) begin
                        col_n   = '0;
                        hold_n  = rdata;
                        vld_n   = 1'b1;
                        state_n = S_REPLAY;
                    end else begin
                        col_n = col + 1'b1;
                        vld_n = 1'b0;
                    end
                end
                if (xfer_in) begin
                    hold_n = bus.i_data;
                    vld_n  = 1'b1;
                end
            end
            S_REPLAY: begin
                if (xfer_out && dup) begin
                    if (col == LAST_COL) begin
                        col_n   = '0;
                        vld_n   = 1'b0;
                        row_n   = (row == LAST_ROW) ? '0 : row + 1'b1;
                        state_n = S_FIRST;
                    end else begin
                        col_n  = col + 1'b1;
                        hold_n = rdata;
                    end
                end
            end
            default: state_n = S_FIRST;
        endcase
    end

    // Stage p1: hold register and control state
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FIRST;
            hold_p1 <= '0;
            vld_p1  <= 1'b0;
            col     <= '0;
            row     <= '0;
            dup     <= 1'b0;
        end else begin
            state   <= state_n;
            hold_p1 <= hold_n;
            vld_p1  <= vld_n;
            col     <= col_n;
            row     <= row_n;
            dup     <= dup_n;
        end
    end

    assign bus.i_ack  = i_ack_c;
    assign bus.o_rdy  = vld_p1;
    assign bus.o_data = hold_p1;

`ifdef UPSAMPLE_LAST_EN
    logic last_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_p1 <= 1'b0;
        end else begin
            last_p1 <= vld_n && (state_n == S_REPLAY) && (row_n == LAST_ROW) &&
                       (col_n == LAST_COL) && dup_n;
        end
    end

    assign bus.o_last = last_p1;
`endif

endmodule
